// File: rtl/fifo_flow_if.sv
// Push/pop handshake bundle for fifo_flow.
// A beat transfers on a rising clock edge when valid and ready are both high. Valid never waits on ready.
// The slave modport is the FIFO side, and the master modport is the producer/consumer side.
interface fifo_flow_if #(
  parameter type DATA_TYPE_t = logic [31:0]
);
  logic       push_valid;
  logic       push_ready;
  DATA_TYPE_t push_data;
  logic       pop_valid;
  logic       pop_ready;
  DATA_TYPE_t pop_data;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/fifo_flow.sv
// Synchronous FWFT FIFO with a true occupancy count, runtime almost-full/empty thresholds and a flush.
// Optional high-water-mark output when FIFO_FLOW_HWM_EN is defined.
module fifo_flow #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 16,
  parameter type DATA_TYPE_t = logic [WIDTH-1:0],
  localparam int ADDR_WIDTH  = $clog2(DEPTH),
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  fifo_flow_if.slave             flow_if,
  input  logic                   i_clear,
  input  logic [COUNT_WIDTH-1:0] i_af_thresh,
  input  logic [COUNT_WIDTH-1:0] i_ae_thresh,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic                   o_almost_empty
`ifdef FIFO_FLOW_HWM_EN
  ,
  output logic [COUNT_WIDTH-1:0] o_high_water
`endif
);

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  DATA_TYPE_t             mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   push;
  logic                   pop;

  assign o_empty            = (count_q == '0);
  assign o_full             = (count_q == FULL_COUNT);
  assign o_almost_full      = (count_q >= i_af_thresh);
  assign o_almost_empty     = (count_q <= i_ae_thresh);
  assign o_count            = count_q;

  // No write-through when full: ready depends only on the count register.
  assign flow_if.push_ready = ~o_full;
  assign flow_if.pop_valid  = ~o_empty;
  assign flow_if.pop_data   = mem_q[rd_ptr_q];

  assign push = flow_if.push_valid & flow_if.push_ready;
  assign pop  = flow_if.pop_valid & flow_if.pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; a flush or reset only moves the pointers.
  always_ff @(posedge i_clock) begin
    if (push && !i_clear && !i_reset) begin
      mem_q[wr_ptr_q] <= flow_if.push_data;
    end
  end

`ifdef FIFO_FLOW_HWM_EN
  logic [COUNT_WIDTH-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (i_clear) begin
      hwm_d = '0;
    end else if (count_q > hwm_q) begin
      hwm_d = count_q;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign o_high_water = hwm_q;
`endif

endmodule

// File: tb/tb_fifo_flow.sv
// Directed bench for fifo_flow: DEPTH=4 for fill/drain/flags/clear, and DEPTH=5 for wrap streaming.
module tb_fifo_flow;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  int         checks;
  int         errors;
  logic [W-1:0] exp_q[$];

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- DEPTH=4 instance ----
  fifo_flow_if #(.DATA_TYPE_t(logic [W-1:0])) if4 ();
  logic       clr4;
  logic [2:0] af4, ae4, cnt4;
  logic       empty4, full4, afull4, aempty4;
`ifdef FIFO_FLOW_HWM_EN
  logic [2:0] hwm4;
`endif

  fifo_flow #(.WIDTH(W), .DEPTH(4), .DATA_TYPE_t(logic [W-1:0])) dut4 (
    .i_clock        (clk),
    .i_reset        (rst),
    .flow_if        (if4),
    .i_clear        (clr4),
    .i_af_thresh    (af4),
    .i_ae_thresh    (ae4),
    .o_count        (cnt4),
    .o_empty        (empty4),
    .o_full         (full4),
    .o_almost_full  (afull4),
    .o_almost_empty (aempty4)
`ifdef FIFO_FLOW_HWM_EN
    ,
    .o_high_water   (hwm4)
`endif
  );

  // ---- DEPTH=5 instance ----
  fifo_flow_if #(.DATA_TYPE_t(logic [W-1:0])) if5 ();
  logic       clr5;
  logic [2:0] af5, ae5, cnt5;
  logic       empty5, full5, afull5, aempty5;
`ifdef FIFO_FLOW_HWM_EN
  logic [2:0] hwm5;
`endif

  fifo_flow #(.WIDTH(W), .DEPTH(5), .DATA_TYPE_t(logic [W-1:0])) dut5 (
    .i_clock        (clk),
    .i_reset        (rst),
    .flow_if        (if5),
    .i_clear        (clr5),
    .i_af_thresh    (af5),
    .i_ae_thresh    (ae5),
    .o_count        (cnt5),
    .o_empty        (empty5),
    .o_full         (full5),
    .o_almost_full  (afull5),
    .o_almost_empty (aempty5)
`ifdef FIFO_FLOW_HWM_EN
    ,
    .o_high_water   (hwm5)
`endif
  );

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---- stimulus + scoreboard ----
  initial begin
    logic [W-1:0] exp_head;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clr4 = 1'b0; af4 = 3'd3; ae4 = 3'd1;
    if4.push_valid = 1'b0; if4.push_data = '0; if4.pop_ready = 1'b0;
    clr5 = 1'b0; af5 = 3'd5; ae5 = 3'd0;
    if5.push_valid = 1'b0; if5.push_data = '0; if5.pop_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_count", 32'(cnt4), 0);
    check("rst_empty", 32'(empty4), 1);
    check("rst_full", 32'(full4), 0);
    check("rst_push_ready", 32'(if4.push_ready), 1);
    check("rst_pop_valid", 32'(if4.pop_valid), 0);
    check("rst_afull", 32'(afull4), 0);
    check("rst_aempty", 32'(aempty4), 1);
`ifdef FIFO_FLOW_HWM_EN
    check("rst_hwm", 32'(hwm4), 0);
`endif

    // Fill with A1..A4
    for (int i = 0; i < 4; i++) begin
      if4.push_valid = 1'b1;
      if4.push_data  = W'(8'hA1 + i);
      tick();
      check($sformatf("fill_count%0d", i), 32'(cnt4), 32'(i + 1));
      check($sformatf("fill_afull%0d", i), 32'(afull4), (i >= 2) ? 32'd1 : 32'd0);
      if (i == 0) begin
        check("fwft_valid", 32'(if4.pop_valid), 1);
        check("fwft_data", 32'(if4.pop_data), 32'hA1);
      end
    end
    check("full_flag", 32'(full4), 1);
    check("full_push_ready", 32'(if4.push_ready), 0);
    if4.push_data = 8'hA5;
    tick();
    check("full_no_accept", 32'(cnt4), 4);
    check("full_head_stable", 32'(if4.pop_data), 32'hA1);

    // Drain in order
    if4.push_valid = 1'b0;
    if4.pop_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(if4.pop_valid), 1);
      check($sformatf("drain_data%0d", i), 32'(if4.pop_data), 32'(8'hA1 + i));
      tick();
    end
    check("drain_empty", 32'(empty4), 1);
    check("drain_pop_valid", 32'(if4.pop_valid), 0);

    // Refill B1..B4, then push+pop while full
    if4.pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if4.push_valid = 1'b1;
      if4.push_data  = W'(8'hB1 + i);
      tick();
    end
    if4.push_data = 8'hB5;
    if4.pop_ready = 1'b1;
    check("fullpp_push_ready", 32'(if4.push_ready), 0);
    tick();
    check("fullpp_count", 32'(cnt4), 3);
    check("fullpp_head", 32'(if4.pop_data), 32'hB2);
    if4.push_valid = 1'b0;
    tick();
    check("pop_only_count", 32'(cnt4), 2);
    check("pop_only_head", 32'(if4.pop_data), 32'hB3);
    if4.push_valid = 1'b1;
    if4.push_data  = 8'hC1;
    tick();
    check("pp_count_a", 32'(cnt4), 2);
    check("pp_head_a", 32'(if4.pop_data), 32'hB4);
    if4.push_data = 8'hC2;
    tick();
    check("pp_count_b", 32'(cnt4), 2);
    check("pp_head_b", 32'(if4.pop_data), 32'hC1);
    if4.push_valid = 1'b0;
    if4.pop_ready  = 1'b0;
`ifdef FIFO_FLOW_HWM_EN
    check("hwm_peak", 32'(hwm4), 4);
`endif

    // Mid-stream reset discards contents
    do_reset();
    check("rst2_count", 32'(cnt4), 0);
    check("rst2_pop_valid", 32'(if4.pop_valid), 0);

    // Clear with a concurrent push at count 3
    for (int i = 0; i < 3; i++) begin
      if4.push_valid = 1'b1;
      if4.push_data  = W'(8'hD1 + i);
      tick();
    end
    if4.push_valid = 1'b0;
    tick();
    check("pre_clear_count", 32'(cnt4), 3);
`ifdef FIFO_FLOW_HWM_EN
    check("pre_clear_hwm", 32'(hwm4), 3);
`endif
    clr4 = 1'b1;
    if4.push_valid = 1'b1;
    if4.push_data  = 8'hEE;
    tick();
    check("clear_count", 32'(cnt4), 0);
    check("clear_empty", 32'(empty4), 1);
`ifdef FIFO_FLOW_HWM_EN
    check("clear_hwm", 32'(hwm4), 0);
`endif
    clr4 = 1'b0;
    if4.push_valid = 1'b0;
    tick();
    check("clear_push_dropped", 32'(cnt4), 0);
    if4.push_valid = 1'b1;
    if4.push_data  = 8'hF1;
    tick();
    check("post_clear_count", 32'(cnt4), 1);
    check("post_clear_head", 32'(if4.pop_data), 32'hF1);

    // Push+pop on empty: only the push happens
    if4.push_valid = 1'b0;
    if4.pop_ready  = 1'b1;
    tick();
    check("empty_again", 32'(empty4), 1);
    if4.push_valid = 1'b1;
    if4.push_data  = 8'hF2;
    tick();
    check("emptypp_count", 32'(cnt4), 1);
    check("emptypp_head", 32'(if4.pop_data), 32'hF2);
    if4.push_valid = 1'b0;
    if4.pop_ready  = 1'b0;

    // Runtime thresholds at count 1
    af4 = 3'd0; ae4 = 3'd0;
    #1;
    check("af_zero_forces", 32'(afull4), 1);
    check("ae_zero_count1", 32'(aempty4), 0);
    ae4 = 3'd4;
    #1;
    check("ae_depth_forces", 32'(aempty4), 1);
    af4 = 3'd2;
    #1;
    check("af_two_count1", 32'(afull4), 0);

    // DEPTH=5 streaming across pointer wrap
    tick();
    do_reset();
    if5.push_valid = 1'b1;
    if5.push_data  = 8'h10;
    exp_q.push_back(8'h10);
    tick();
    check("s5_first_count", 32'(cnt5), 1);
    if5.pop_ready = 1'b1;
    for (int k = 1; k < 12; k++) begin
      if5.push_data = W'(8'h10 + k);
      exp_head = exp_q.pop_front();
      check($sformatf("s5_data%0d", k), 32'(if5.pop_data), 32'(exp_head));
      exp_q.push_back(W'(8'h10 + k));
      tick();
      check($sformatf("s5_count%0d", k), 32'(cnt5), 1);
    end
    if5.push_valid = 1'b0;
    exp_head = exp_q.pop_front();
    check("s5_last_data", 32'(if5.pop_data), 32'(exp_head));
    tick();
    check("s5_empty", 32'(empty5), 1);
    if5.pop_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
